// File: rtl/syn_fifo_flags.sv
// syn_fifo_flags: single-clock FIFO with almost-full/empty thresholds, occupancy count,
// overflow/underflow protection and selectable first-word-fall-through read.
module syn_fifo_flags #(
    parameter int data_width = 8,
    parameter int depth      = 8,
    parameter int af_level   = depth - 2,
    parameter int ae_level   = 2,
    parameter bit fwft       = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [data_width-1:0]   i_wr_data,
    input  logic                    i_rd_en,
    output logic [data_width-1:0]   o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_fifo_full,
    output logic                    o_fifo_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic [$clog2(depth):0]  o_data_count,
    output logic                    o_overflow,
    output logic                    o_underflow
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    logic [data_width-1:0] r_mem [depth];
    logic [aw-1:0]         r_wr_ptr, r_rd_ptr;
    logic [cw-1:0]         r_count, w_count_nxt;
    logic [data_width-1:0] r_rd_data;
    logic                  r_rd_valid, r_overflow, r_underflow;
    logic                  w_full, w_empty, w_wr_acc, w_rd_acc;
    assign w_full   = r_count == cw'(depth);
    assign w_empty  = r_count == '0;
    assign w_rd_acc = i_rd_en && !w_empty;
    // a full FIFO can still take a write when a read frees the head slot in the same cycle
    assign w_wr_acc = i_wr_en && (!w_full || w_rd_acc);
    always_comb begin
        w_count_nxt = (w_wr_acc && !w_rd_acc) ? r_count + cw'(1) :
                      (w_rd_acc && !w_wr_acc) ? r_count - cw'(1) : r_count;
    end
    always_ff @(posedge i_clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= i_wr_data;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= (r_wr_ptr == aw'(depth - 1)) ? '0 : r_wr_ptr + aw'(1);
            if (w_rd_acc) begin
                r_rd_ptr  <= (r_rd_ptr == aw'(depth - 1)) ? '0 : r_rd_ptr + aw'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_count     <= w_count_nxt;
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= i_wr_en && !w_wr_acc;
            r_underflow <= i_rd_en && !w_rd_acc;
        end
    end
    assign o_rd_data      = fwft ? r_mem[r_rd_ptr] : r_rd_data;
    assign o_rd_valid     = fwft ? !w_empty : r_rd_valid;
    assign o_fifo_full    = w_full;
    assign o_fifo_empty   = w_empty;
    assign o_almost_full  = r_count >= cw'(af_level);
    assign o_almost_empty = r_count <= cw'(ae_level);
    assign o_data_count   = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;
endmodule

// File: tb/tb_syn_fifo_flags.sv
// tb_syn_fifo_flags: table-driven and scoreboard checks of syn_fifo_flags in standard and FWFT modes.
module tb_syn_fifo_flags;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    logic [7:0] wd0 = 0, wd1 = 0;
    logic [7:0] rdat0, rdat1;
    logic       rv0, full0, empty0, af0, ae0, ovf0, unf0;
    logic       rv1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0] cnt0, cnt1;

    syn_fifo_flags #(.data_width(8), .depth(8), .af_level(6), .ae_level(2), .fwft(1'b0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr0), .i_wr_data(wd0), .i_rd_en(rd0),
        .o_rd_data(rdat0), .o_rd_valid(rv0), .o_fifo_full(full0), .o_fifo_empty(empty0),
        .o_almost_full(af0), .o_almost_empty(ae0), .o_data_count(cnt0),
        .o_overflow(ovf0), .o_underflow(unf0));

    syn_fifo_flags #(.data_width(8), .depth(8), .af_level(6), .ae_level(2), .fwft(1'b1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr1), .i_wr_data(wd1), .i_rd_en(rd1),
        .o_rd_data(rdat1), .o_rd_valid(rv1), .o_fifo_full(full1), .o_fifo_empty(empty1),
        .o_almost_full(af1), .o_almost_empty(ae1), .o_data_count(cnt1),
        .o_overflow(ovf1), .o_underflow(unf1));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic [7:0] mq[$];
    logic [7:0] sb[$];

    // one clock of traffic on the standard-mode FIFO, checked against a queue model
    task automatic cyc0(input logic w, input logic [7:0] d, input logic r);
        bit ra, wa;
        int n;
        ra = r && mq.size() > 0;
        wa = w && (mq.size() < 8 || ra);
        wr0 = w; wd0 = d; rd0 = r;
        @(posedge clk);
        if (ra) sb.push_back(mq.pop_front());
        if (wa) mq.push_back(d);
        #1;
        wr0 = 0; rd0 = 0;
        n = mq.size();
        chk("count", 32'(cnt0), 32'(n));
        chk("overflow", 32'(ovf0), 32'(w && !wa));
        chk("underflow", 32'(unf0), 32'(r && !ra));
        chk("full", 32'(full0), 32'(n == 8));
        chk("empty", 32'(empty0), 32'(n == 0));
        chk("almost_full", 32'(af0), 32'(n >= 6));
        chk("almost_empty", 32'(ae0), 32'(n <= 2));
        chk("rd_valid", 32'(rv0), 32'(ra));
        if (ra) chk("rd_data", 32'(rdat0), 32'(sb.pop_front()));
    endtask

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
    } vec_t;
    vec_t tbl[18];

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 8'(i + 1), 1'b0, 4'(i + 1), 1'b0, 1'b0};
        tbl[8] = '{1'b1, 8'hAA, 1'b0, 4'd8, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) tbl[9 + i] = '{1'b0, 8'h00, 1'b1, 4'(7 - i), 1'b0, 1'b0};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_empty", 32'(empty0), 1);
        chk("rst_aempty", 32'(ae0), 1);
        chk("rst_full", 32'(full0), 0);
        chk("rst_afull", 32'(af0), 0);
        chk("rst_valid", 32'(rv0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_unf", 32'(unf0), 0);
        chk("rst_rd_data", 32'(rdat0), 0);
        rst = 0;

        // fill, overflow while full, drain past empty
        for (int i = 0; i < 18; i++) begin
            cyc0(tbl[i].w, tbl[i].d, tbl[i].r);
            chk("tbl_count", 32'(cnt0), 32'(tbl[i].cnt));
            chk("tbl_ovf", 32'(ovf0), 32'(tbl[i].ovf));
            chk("tbl_unf", 32'(unf0), 32'(tbl[i].unf));
        end

        // preload then simultaneous traffic wrapping both pointers
        for (int i = 0; i < 5; i++) cyc0(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc0(1'b1, 8'(8'h20 + i), 1'b1);
            chk("wrap_count", 32'(cnt0), 5);
        end
        for (int i = 0; i < 5; i++) cyc0(1'b0, 8'h00, 1'b1);

        // simultaneous read+write at full and at empty
        for (int i = 0; i < 8; i++) cyc0(1'b1, 8'(8'h30 + i), 1'b0);
        cyc0(1'b1, 8'h99, 1'b1);
        chk("full_rw_count", 32'(cnt0), 8);
        chk("full_rw_ovf", 32'(ovf0), 0);
        for (int i = 0; i < 8; i++) cyc0(1'b0, 8'h00, 1'b1);
        cyc0(1'b1, 8'h77, 1'b1);
        chk("empty_rw_unf", 32'(unf0), 1);
        chk("empty_rw_count", 32'(cnt0), 1);
        cyc0(1'b0, 8'h00, 1'b1);
        chk("sb_drained", 32'(sb.size()), 0);

        // first-word fall-through instance
        chk("f_valid_idle", 32'(rv1), 0);
        wr1 = 1; wd1 = 8'h55;
        @(posedge clk); #1;
        wr1 = 0;
        chk("f_valid_55", 32'(rv1), 1);
        chk("f_data_55", 32'(rdat1), 32'h55);
        chk("f_count_1", 32'(cnt1), 1);
        wr1 = 1; wd1 = 8'h66;
        @(posedge clk); #1;
        wr1 = 0;
        chk("f_head_held", 32'(rdat1), 32'h55);
        chk("f_count_2", 32'(cnt1), 2);
        rd1 = 1;
        @(posedge clk); #1;
        rd1 = 0;
        chk("f_data_66", 32'(rdat1), 32'h66);
        chk("f_valid_66", 32'(rv1), 1);
        chk("f_count_pop", 32'(cnt1), 1);
        wr1 = 1; wd1 = 8'h77;
        @(posedge clk); #1;
        wr1 = 0;
        #2 rst = 1;
        #1;
        chk("f_rst_valid", 32'(rv1), 0);
        chk("f_rst_empty", 32'(empty1), 1);
        chk("f_rst_count", 32'(cnt1), 0);
        @(posedge clk); #1;
        rst = 0;
        rd1 = 1;
        @(posedge clk); #1;
        rd1 = 0;
        chk("f_unf", 32'(unf1), 1);
        chk("f_unf_valid", 32'(rv1), 0);
        @(posedge clk); #1;
        chk("f_unf_pulse", 32'(unf1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/syn_fifo_flags.md
Name: syn_fifo_flags

Overview:
- Parametrised successor of the team's single-clock synchronous FIFO.
- Adds almost-full/almost-empty thresholds, an occupancy count output, overflow/underflow protection with error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between single-clock producer/consumer blocks that need early back-pressure and protected pointers.

Parameters:
- data_width, 8, width of each stored word.
- depth, 8, number of entries; any integer >= 2 (power of 2 not required).
- af_level, depth-2, almost_full asserts when data_count >= af_level; legal range 1..depth.
- ae_level, 2, almost_empty asserts when data_count <= ae_level; legal range 0..depth-1.
- fwft, 0, read mode: 0 = standard registered read, 1 = first-word fall-through.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- wr_en  in  1  write request.
- wr_data  in  data_width  write data, sampled when a write is accepted.
- rd_en  in  1  read request (fwft=1: pop/acknowledge of the head word).
- rd_data  out  data_width  read data.
- rd_valid  out  1  rd_data holds a valid word (definition depends on mode).
- fifo_full  out  1  data_count == depth.
- fifo_empty  out  1  data_count == 0.
- almost_full  out  1  data_count >= af_level.
- almost_empty  out  1  data_count <= ae_level.
- data_count  out  $clog2(depth)+1  current occupancy, 0..depth.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (asynchronous, immediate on rst=1): wr_ptr=0, rd_ptr=0, data_count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Resulting flags: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0. Memory contents are not reset. Reset mid-operation discards all stored data.
- Write acceptance: wr_acc = wr_en && (!fifo_full || rd_acc).
  - Accepted write stores wr_data at wr_ptr.
  - wr_ptr advances by 1 and wraps from depth-1 to 0 by compare, not by overflow.
- Read acceptance: rd_acc = rd_en && !fifo_empty.
  - rd_ptr advances by 1 with the same wrap rule.
- Rejected requests:
  - wr_en && !wr_acc pulses overflow for 1 cycle on the next edge; memory, pointers and count are unchanged.
  - rd_en && !rd_acc pulses underflow the same way.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
  - Never exceeds depth and never wraps below 0.
- Simultaneous read and write:
  - When full: both accepted; the old head word is read, the new word occupies the freed slot, count stays depth, no overflow.
  - When empty: write accepted, read rejected, underflow pulses, count becomes 1.
- All status flags are combinational decodes of the registered data_count, so they update 1 cycle after the causing edge.
- fwft=0 (standard mode):
  - On rd_acc, rd_data <= mem[rd_ptr] at the clock edge, and rd_valid pulses high for exactly that following cycle.
  - rd_data holds its last value otherwise.
  - Read latency is 1 cycle.
- fwft=1 (fall-through mode):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !fifo_empty.
  - A word written into an empty FIFO appears on rd_data 1 cycle after its write edge.
  - rd_en acts as an acknowledgement; the next word appears in the same cycle the pointer advances.
  - rd_data is don't-care while rd_valid=0.
- No combinational path from wr_en/rd_en to any output, except that rd_data in fwft=1 follows rd_ptr.

Test Plan:
- Reset then fill (depth=8, af_level=6, ae_level=2): write 0x01..0x08 on consecutive cycles. Required:
  - almost_empty deasserts when count=3.
  - almost_full asserts when count=6.
  - fifo_full=1 and data_count=8 after the 8th write.
- Overflow while full: write 0xAA once more. Required: overflow pulses 1 cycle, data_count stays 8, subsequent reads return 0x01..0x08 only.
- Drain with fwft=0: assert rd_en 9 cycles. Required:
  - rd_data=0x01..0x08 each 1 cycle after its rd_en, with rd_valid high.
  - The 9th read pulses underflow.
  - fifo_empty=1 and data_count=0.
- Wrap and simultaneous traffic: preload 5, then assert wr_en and rd_en together for 20 cycles with an incrementing pattern. Required: output order is exact, data_count stays 5, neither error flag fires, both pointers wrap past 7->0.
- Full and empty simultaneous edges:
  - At count=8, assert wr_en+rd_en: no overflow, count stays 8.
  - At count=0, assert wr_en+rd_en: underflow pulses, count becomes 1.
- FWFT mode (fwft=1):
  - Write 0x55 into an empty FIFO: rd_valid=1 and rd_data=0x55 the next cycle without rd_en.
  - Then write 0x66 and pulse rd_en: rd_data=0x66 the following cycle.
  - Assert rst mid-stream: rd_valid=0 and fifo_empty=1 immediately.
